// File: rtl/ioctl_rom_router.sv
// rtl/ioctl_rom_router.sv - hps_io download router: ROM word packing into N regions, DIP/mod capture.
// Optional checksum on rom_sum: define IOCTL_ROM_ROUTER_CHECKSUM_EN.
module ioctl_rom_router #(
  parameter int NUM_REGIONS = 4,
  parameter int REGION_AW   = 16,
  parameter int DATA_W      = 16,
  parameter int ROM_INDEX   = 0,
  parameter int MOD_INDEX   = 1,
  parameter int DIP_INDEX   = 254,
  parameter int DIP_BYTES   = 8,
  localparam int BPW        = DATA_W / 8,
  localparam int LW         = $clog2(BPW),
  localparam int WAW        = REGION_AW - LW
) (
  input  logic                     clk_sys,
  input  logic                     RESET_n,
  input  logic                     ioctl_download,
  input  logic [7:0]               ioctl_index,
  input  logic                     ioctl_wr,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  output logic                     ioctl_wait,
  output logic [NUM_REGIONS-1:0]   dn_we,
  output logic [WAW-1:0]           dn_addr,
  output logic [DATA_W-1:0]        dn_data,
  output logic [BPW-1:0]           dn_be,
  input  logic                     dn_ready,
  output logic [8*DIP_BYTES-1:0]   dip_bank,
  output logic [7:0]               mod_byte,
  output logic                     dl_done,
  output logic                     dl_overflow,
  output logic [15:0]              rom_sum
);

  localparam int RIW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int RGW = 25 - REGION_AW;
  localparam int LSW = (LW > 0) ? LW : 1;

  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, FLUSH, DONE} state_t;

  state_t                  state_q;
  logic                    rom_dl_q, end_q, dl_done_q, ovf_q;
  logic [DATA_W-1:0]       acc_data_q;
  logic [BPW-1:0]          acc_mask_q;
  logic [WAW-1:0]          acc_word_q;
  logic [RIW-1:0]          acc_reg_q;
  logic                    skid_v_q;
  logic [7:0]              skid_byte_q;
  logic [LSW-1:0]          skid_lane_q;
  logic [WAW-1:0]          skid_word_q;
  logic [RIW-1:0]          skid_reg_q;
  logic [NUM_REGIONS-1:0]  dn_we_q;
  logic [WAW-1:0]          dn_addr_q;
  logic [DATA_W-1:0]       dn_data_q;
  logic [BPW-1:0]          dn_be_q;
  logic [8*DIP_BYTES-1:0]  dip_q;
  logic [7:0]              mod_q;

  logic [RGW-1:0]          in_region;
  logic                    in_range;
  logic [RIW-1:0]          in_reg;
  logic [WAW-1:0]          in_word;
  logic [LSW-1:0]          in_lane;
  logic                    rom_active, rom_rise, rom_fall, rom_wr, rom_byte;
  logic                    split;
  logic [DATA_W-1:0]       place_data_d;
  logic [BPW-1:0]          place_mask_d;
  logic                    ld_v;
  logic [7:0]              ld_byte;
  logic [LSW-1:0]          ld_lane;
  logic [WAW-1:0]          ld_word;
  logic [RIW-1:0]          ld_reg;
  logic [DATA_W-1:0]       ld_data_d;
  logic [BPW-1:0]          ld_mask_d;

  assign in_region  = ioctl_addr[24:REGION_AW];
  assign in_range   = in_region < RGW'(NUM_REGIONS);
  assign in_reg     = in_region[RIW-1:0];
  assign in_word    = ioctl_addr[REGION_AW-1:LW];
  assign in_lane    = (LW == 0) ? '0 : ioctl_addr[LSW-1:0];

  // A byte in the same cycle as the download falling edge is still accepted.
  assign rom_active = ioctl_download && (ioctl_index == 8'(ROM_INDEX));
  assign rom_rise   = rom_active && !rom_dl_q;
  assign rom_fall   = rom_dl_q && !rom_active;
  assign rom_wr     = ioctl_wr && (ioctl_index == 8'(ROM_INDEX)) && (ioctl_download || rom_dl_q);
  assign rom_byte   = rom_wr && in_range;

  assign split = (acc_mask_q != '0) && ((in_word != acc_word_q) || (in_reg != acc_reg_q));
  assign place_data_d = (((acc_mask_q == '0) ? '0 : acc_data_q) & ~(DATA_W'(8'hFF) << {in_lane, 3'b000}))
                      | (DATA_W'(ioctl_dout) << {in_lane, 3'b000});
  assign place_mask_d = acc_mask_q | (BPW'(1) << in_lane);

  // Word that starts once an issue completes: the skid byte, else a byte arriving right now.
  assign ld_v      = skid_v_q || rom_byte;
  assign ld_byte   = skid_v_q ? skid_byte_q : ioctl_dout;
  assign ld_lane   = skid_v_q ? skid_lane_q : in_lane;
  assign ld_word   = skid_v_q ? skid_word_q : in_word;
  assign ld_reg    = skid_v_q ? skid_reg_q  : in_reg;
  assign ld_data_d = DATA_W'(ld_byte) << {ld_lane, 3'b000};
  assign ld_mask_d = BPW'(1) << ld_lane;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      rom_dl_q    <= 1'b0;
      end_q       <= 1'b0;
      dl_done_q   <= 1'b0;
      ovf_q       <= 1'b0;
      acc_data_q  <= '0;
      acc_mask_q  <= '0;
      acc_word_q  <= '0;
      acc_reg_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_byte_q <= '0;
      skid_lane_q <= '0;
      skid_word_q <= '0;
      skid_reg_q  <= '0;
      dn_we_q     <= '0;
      dn_addr_q   <= '0;
      dn_data_q   <= '0;
      dn_be_q     <= '0;
    end else begin
      rom_dl_q  <= rom_active;
      dl_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rom_rise) begin
            acc_data_q <= '0;
            acc_mask_q <= '0;
            skid_v_q   <= 1'b0;
            end_q      <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= COLLECT;
          end
        end
        COLLECT: begin
          if (rom_byte) begin
            if (split) begin
              dn_we_q     <= NUM_REGIONS'(1) << acc_reg_q;
              dn_addr_q   <= acc_word_q;
              dn_data_q   <= acc_data_q;
              dn_be_q     <= acc_mask_q;
              skid_v_q    <= 1'b1;
              skid_byte_q <= ioctl_dout;
              skid_lane_q <= in_lane;
              skid_word_q <= in_word;
              skid_reg_q  <= in_reg;
              end_q       <= rom_fall;
              state_q     <= ISSUE;
            end else begin
              acc_data_q <= place_data_d;
              acc_mask_q <= place_mask_d;
              acc_word_q <= in_word;
              acc_reg_q  <= in_reg;
              if (&place_mask_d) begin
                dn_we_q   <= NUM_REGIONS'(1) << in_reg;
                dn_addr_q <= in_word;
                dn_data_q <= place_data_d;
                dn_be_q   <= place_mask_d;
                end_q     <= rom_fall;
                state_q   <= ISSUE;
              end else if (rom_fall) begin
                state_q <= FLUSH;
              end
            end
          end else if (rom_fall) begin
            state_q <= FLUSH;
          end
        end
        ISSUE: begin
          if (rom_fall) end_q <= 1'b1;
          if (!dn_ready) begin
            if (rom_byte && !skid_v_q) begin
              skid_v_q    <= 1'b1;
              skid_byte_q <= ioctl_dout;
              skid_lane_q <= in_lane;
              skid_word_q <= in_word;
              skid_reg_q  <= in_reg;
            end
          end else begin
            dn_we_q  <= '0;
            skid_v_q <= 1'b0;
            if (ld_v) begin
              acc_data_q <= ld_data_d;
              acc_mask_q <= ld_mask_d;
              acc_word_q <= ld_word;
              acc_reg_q  <= ld_reg;
              if (&ld_mask_d) begin
                dn_we_q   <= NUM_REGIONS'(1) << ld_reg;
                dn_addr_q <= ld_word;
                dn_data_q <= ld_data_d;
                dn_be_q   <= ld_mask_d;
              end else begin
                state_q <= (end_q || rom_fall) ? FLUSH : COLLECT;
              end
            end else begin
              acc_mask_q <= '0;
              state_q    <= (end_q || rom_fall) ? DONE : COLLECT;
            end
          end
        end
        FLUSH: begin
          if (acc_mask_q != '0) begin
            dn_we_q   <= NUM_REGIONS'(1) << acc_reg_q;
            dn_addr_q <= acc_word_q;
            dn_data_q <= acc_data_q;
            dn_be_q   <= acc_mask_q;
            end_q     <= 1'b1;
            state_q   <= ISSUE;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          dl_done_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (rom_wr && !in_range) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      dip_q <= '0;
      mod_q <= '0;
    end else if (ioctl_wr) begin
      if (ioctl_index == 8'(DIP_INDEX)) begin
        for (int k = 0; k < DIP_BYTES; k++) begin
          if (ioctl_addr == 25'(k)) dip_q[8*k +: 8] <= ioctl_dout;
        end
      end
      if (ioctl_index == 8'(MOD_INDEX)) mod_q <= ioctl_dout;
    end
  end

`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        sum_add;
  assign sum_add = rom_byte && ((state_q == COLLECT) || ((state_q == ISSUE) && !skid_v_q));
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n)                         sum_q <= '0;
    else if ((state_q == IDLE) && rom_rise) sum_q <= '0;
    else if (sum_add)                     sum_q <= sum_q + 16'(ioctl_dout);
  end
  assign rom_sum = sum_q;
`else
  assign rom_sum = 16'h0000;
`endif

  assign ioctl_wait  = (state_q == ISSUE);
  assign dn_we       = dn_we_q;
  assign dn_addr     = dn_addr_q;
  assign dn_data     = dn_data_q;
  assign dn_be       = dn_be_q;
  assign dl_done     = dl_done_q;
  assign dl_overflow = ovf_q;
  assign dip_bank    = dip_q;
  assign mod_byte    = mod_q;

endmodule

// File: tb/tb_ioctl_rom_router.sv
// tb/tb_ioctl_rom_router.sv - directed self-checking bench for ioctl_rom_router (default parameters).
module tb_ioctl_rom_router;

  logic        clk_sys = 1'b0;
  logic        RESET_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic [3:0]  dn_we;
  logic [14:0] dn_addr;
  logic [15:0] dn_data;
  logic [1:0]  dn_be;
  logic        dn_ready = 1'b1;
  logic [63:0] dip_bank;
  logic [7:0]  mod_byte;
  logic        dl_done;
  logic        dl_overflow;
  logic [15:0] rom_sum;

`ifdef IOCTL_ROM_ROUTER_CHECKSUM_EN
  localparam logic [15:0] EXP_SUM = 16'h0101;
`else
  localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

  ioctl_rom_router dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .dn_we(dn_we), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_be(dn_be), .dn_ready(dn_ready), .dip_bank(dip_bank),
    .mod_byte(mod_byte), .dl_done(dl_done), .dl_overflow(dl_overflow), .rom_sum(rom_sum)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [3:0]  we;
    logic [14:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wr_t;

  wr_t wq[$];
  int  checks = 0;
  int  errors = 0;

  // Completed sink transfers: dn_we non-zero while dn_ready is high.
  always @(negedge clk_sys)
    if (RESET_n && dn_we != 4'b0000 && dn_ready) wq.push_back({dn_we, dn_addr, dn_data, dn_be});

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit honor);
    int n = 0;
    while (honor && ioctl_wait && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: ioctl_wait still %b after %0d cycles, required 0", ioctl_wait, n);
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl(output int dones);
    dones = 0;
    ioctl_download = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dl_done) dones++;
    end
  endtask

  task automatic test_reset();
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b required 0", ioctl_wait); end
    checks++; if (dn_we !== 4'b0) begin errors++; $display("FAIL reset_dn_we: got %b required 0000", dn_we); end
    checks++; if ({dn_addr, dn_data, dn_be} !== 33'd0) begin errors++; $display("FAIL reset_dn_bus: got %h required 0", {dn_addr, dn_data, dn_be}); end
    checks++; if ({dl_done, dl_overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b required 00", {dl_done, dl_overflow}); end
    checks++; if (rom_sum !== 16'h0) begin errors++; $display("FAIL reset_sum: got %h required 0000", rom_sum); end
    checks++; if ({dip_bank, mod_byte} !== 72'd0) begin errors++; $display("FAIL reset_cfg: got %h required 0", {dip_bank, mod_byte}); end
  endtask

  task automatic test_single_word();
    int dones;
    wq.delete();
    start_dl(8'd0);
    send_byte(25'd0, 8'h11, 1'b1);
    send_byte(25'd1, 8'h22, 1'b1);
    checks++; if (dn_we !== 4'b0001) begin errors++; $display("FAIL word_we: got %b required 0001", dn_we); end
    checks++; if (dn_addr !== 15'd0) begin errors++; $display("FAIL word_addr: got %h required 0", dn_addr); end
    checks++; if (dn_data !== 16'h2211) begin errors++; $display("FAIL word_data: got %h required 2211", dn_data); end
    checks++; if (dn_be !== 2'b11) begin errors++; $display("FAIL word_be: got %b required 11", dn_be); end
    end_dl(dones);
    checks++; if (dones !== 1) begin errors++; $display("FAIL word_done: got %0d pulses required 1", dones); end
    checks++; if (wq.size() !== 1) begin errors++; $display("FAIL word_count: got %0d writes required 1", wq.size()); end
  endtask

  task automatic test_partial();
    int dones;
    wr_t e0, e1;
    e0 = {4'b0001, 15'd0, 16'h2211, 2'b11};
    e1 = {4'b0001, 15'd1, 16'h0033, 2'b01};
    wq.delete();
    start_dl(8'd0);
    send_byte(25'd0, 8'h11, 1'b1);
    send_byte(25'd1, 8'h22, 1'b1);
    send_byte(25'd2, 8'h33, 1'b1);
    end_dl(dones);
    checks++; if (wq.size() !== 2) begin errors++; $display("FAIL partial_count: got %0d writes required 2", wq.size()); end
    if (wq.size() >= 2) begin
      checks++; if (wq[0] !== e0) begin errors++; $display("FAIL partial_w0: got %h required %h", wq[0], e0); end
      checks++; if (wq[1] !== e1) begin errors++; $display("FAIL partial_w1: got %h required %h", wq[1], e1); end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL partial_done: got %0d pulses required 1", dones); end
  endtask

  task automatic test_stall();
    int dones;
    wr_t e0, e1;
    e0 = {4'b0001, 15'd0, 16'h2211, 2'b11};
    e1 = {4'b0001, 15'd1, 16'h4433, 2'b11};
    wq.delete();
    dn_ready = 1'b0;
    start_dl(8'd0);
    send_byte(25'd0, 8'h11, 1'b1);
    send_byte(25'd1, 8'h22, 1'b1);
    send_byte(25'd2, 8'h33, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL stall_wait[%0d]: got %b required 1", i, ioctl_wait); end
      checks++; if ({dn_we, dn_data} !== {4'b0001, 16'h2211}) begin errors++; $display("FAIL stall_hold[%0d]: got %h required 12211", i, {dn_we, dn_data}); end
      tick();
    end
    dn_ready = 1'b1;
    tick();
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL stall_release: got %b required 0", ioctl_wait); end
    send_byte(25'd3, 8'h44, 1'b1);
    checks++; if (dn_data !== 16'h4433) begin errors++; $display("FAIL stall_skid_word: got %h required 4433", dn_data); end
    end_dl(dones);
    checks++; if (wq.size() !== 2) begin errors++; $display("FAIL stall_count: got %0d writes required 2", wq.size()); end
    if (wq.size() >= 2) begin
      checks++; if (wq[0] !== e0) begin errors++; $display("FAIL stall_w0: got %h required %h", wq[0], e0); end
      checks++; if (wq[1] !== e1) begin errors++; $display("FAIL stall_w1: got %h required %h", wq[1], e1); end
    end
  endtask

  task automatic test_split_region();
    int dones;
    wr_t e0, e1, e2;
    e0 = {4'b0001, 15'd0, 16'h0011, 2'b01};
    e1 = {4'b0001, 15'd2, 16'h0055, 2'b01};
    e2 = {4'b0010, 15'd1, 16'hAA00, 2'b10};
    wq.delete();
    start_dl(8'd0);
    send_byte(25'd0, 8'h11, 1'b1);
    send_byte(25'd4, 8'h55, 1'b1);
    send_byte(25'h10003, 8'hAA, 1'b1);
    end_dl(dones);
    checks++; if (wq.size() !== 3) begin errors++; $display("FAIL split_count: got %0d writes required 3", wq.size()); end
    if (wq.size() >= 3) begin
      checks++; if (wq[0] !== e0) begin errors++; $display("FAIL split_w0: got %h required %h", wq[0], e0); end
      checks++; if (wq[1] !== e1) begin errors++; $display("FAIL split_w1: got %h required %h", wq[1], e1); end
      checks++; if (wq[2] !== e2) begin errors++; $display("FAIL split_w2: got %h required %h", wq[2], e2); end
    end
  endtask

  task automatic test_overflow();
    int dones;
    wq.delete();
    start_dl(8'd0);
    send_byte(25'h40000, 8'h77, 1'b1);
    end_dl(dones);
    checks++; if (wq.size() !== 0) begin errors++; $display("FAIL ovf_nowrite: got %0d writes required 0", wq.size()); end
    checks++; if (dl_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", dl_overflow); end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ovf_done: got %0d pulses required 1", dones); end
    start_dl(8'd0);
    checks++; if (dl_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", dl_overflow); end
    end_dl(dones);
  endtask

  task automatic test_config();
    start_dl(8'd254);
    send_byte(25'd0, 8'h3C, 1'b1);
    send_byte(25'd1, 8'hA5, 1'b1);
    send_byte(25'd9, 8'hFF, 1'b1);
    checks++; if (dip_bank !== 64'h0000_0000_0000_A53C) begin errors++; $display("FAIL dip_bank: got %h required 000000000000a53c", dip_bank); end
    ioctl_index = 8'd1;
    send_byte(25'd0, 8'h01, 1'b1);
    checks++; if (mod_byte !== 8'h01) begin errors++; $display("FAIL mod_byte: got %h required 01", mod_byte); end
    ioctl_download = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    wq.delete();
    dn_ready = 1'b0;
    start_dl(8'd0);
    send_byte(25'd0, 8'h11, 1'b1);
    send_byte(25'd1, 8'h22, 1'b1);
    checks++; if ({dn_we, ioctl_wait} !== 5'b0001_1) begin errors++; $display("FAIL rst_pre: got %b required 00011", {dn_we, ioctl_wait}); end
    #3;
    RESET_n = 1'b0;
    #1;
    checks++; if (dn_we !== 4'b0) begin errors++; $display("FAIL rst_async_we: got %b required 0000", dn_we); end
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL rst_async_wait: got %b required 0", ioctl_wait); end
    ioctl_download = 1'b0;
    dn_ready = 1'b1;
    @(negedge clk_sys);
    RESET_n = 1'b1;
    tick();
    checks++; if ({mod_byte, dip_bank} !== 72'd0) begin errors++; $display("FAIL rst_cfg_clear: got %h required 0", {mod_byte, dip_bank}); end
    start_dl(8'd0);
    send_byte(25'd0, 8'hFF, 1'b1);
    send_byte(25'd1, 8'h02, 1'b1);
    checks++; if ({dn_data, dn_be} !== {16'h02FF, 2'b11}) begin errors++; $display("FAIL rst_clean_word: got %h required 02ff/3", {dn_data, dn_be}); end
    end_dl(dones);
    checks++; if (wq.size() !== 1) begin errors++; $display("FAIL rst_count: got %0d writes required 1", wq.size()); end
    checks++; if (rom_sum !== EXP_SUM) begin errors++; $display("FAIL rom_sum: got %h required %h", rom_sum, EXP_SUM); end
  endtask

  initial begin
    repeat (3) tick();
    RESET_n = 1'b1;
    tick();
    test_reset();
    test_single_word();
    test_partial();
    test_stall();
    test_split_region();
    test_overflow();
    test_config();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ioctl_rom_router.md
Name: ioctl_rom_router

Overview:
- Parametrised download front-end sitting between hps_io ioctl outputs and a core's ROM/config storage.
- Generalises the single-region ROM write, fixed 8-byte DIP capture and mod-byte latch into:
  - N contiguous ROM regions.
  - Byte-to-word packing with byte enables.
  - Per-index config capture.
  - A ready/wait handshake that stalls hps_io through ioctl_wait.
- Emits a done pulse and an overflow flag per download.

Parameters:
- NUM_REGIONS, 4, ROM regions; each is 2**REGION_AW bytes, laid out contiguously from ioctl address 0.
- REGION_AW, 16, byte-address width of one region.
- DATA_W, 16, packed word width; multiple of 8, range 8..64. BPW = DATA_W/8.
- ROM_INDEX, 0, ioctl_index value routed to the ROM regions.
- MOD_INDEX, 1, ioctl_index value whose bytes load the mod register.
- DIP_INDEX, 254, ioctl_index value whose bytes load the DIP bank.
- DIP_BYTES, 8, DIP bank depth in bytes.

Ports:
- clk_sys  in  1  system clock.
- RESET_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download stream index.
- ioctl_wr  in  1  byte strobe, one cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to hps_io.
- dn_we  out  NUM_REGIONS  one-hot region write request.
- dn_addr  out  REGION_AW-log2(BPW)  word address within the region.
- dn_data  out  DATA_W  packed word, little-endian (lowest address in the low byte).
- dn_be  out  BPW  byte enables.
- dn_ready  in  1  sink accepts the word while dn_we != 0.
- dip_bank  out  8*DIP_BYTES  DIP bytes; byte k occupies bits [8k+7:8k].
- mod_byte  out  8  last mod byte received.
- dl_done  out  1  one-cycle pulse when a ROM download completes.
- dl_overflow  out  1  sticky flag: a byte was addressed beyond the last region.
- rom_sum  out  16  checksum (see Optional Feature).

Behaviour:
- Reset (RESET_n low, async), all outputs 0:
  - ioctl_wait, dn_we, dn_addr, dn_data, dn_be, dl_done, dl_overflow, rom_sum.
  - dip_bank and mod_byte cleared to 0.
  - FSM to IDLE; accumulator and lane mask cleared.
- Reset mid-download: any partial word is discarded, no write is issued, and ioctl_wait falls immediately.
- ROM byte routing, when ioctl_wr & ioctl_download & ioctl_index==ROM_INDEX:
  - region = ioctl_addr >> REGION_AW.
  - If region >= NUM_REGIONS: the byte is dropped and dl_overflow is set. It stays set until the next rising edge of ioctl_download for ROM_INDEX.
- FSM states:
  - IDLE: on a rising edge of ioctl_download with ROM_INDEX, clear the accumulator, lane mask and dl_overflow, then go to COLLECT.
  - COLLECT, on an accepted byte:
    - If region or word address differs from the accumulator's and the lane mask is non-zero: go to ISSUE with the old word, and hold the new byte in a one-byte skid register (ioctl_wait asserts in the same cycle).
    - Otherwise: place the byte at lane addr[log2(BPW)-1:0] and set that bit in the lane mask.
    - If the lane mask becomes all ones: go to ISSUE.
  - ISSUE:
    - Drive dn_we one-hot, dn_addr, dn_data, and dn_be = lane mask; ioctl_wait = 1.
    - Hold all outputs stable until dn_ready. Then clear dn_we in the next cycle, load the skid byte if present, and return to COLLECT.
  - FLUSH, entered from COLLECT on a falling edge of ioctl_download:
    - Non-zero lane mask: issue the partial word as in ISSUE, then go to DONE.
    - Empty lane mask: go straight to DONE.
  - DONE: dl_done = 1 for exactly one cycle, then IDLE.
- Simultaneous events:
  - ioctl_wr in the same cycle as the download falling edge: the byte is accepted first, then the flush.
  - dn_ready high in the same cycle dn_we first asserts: the transfer completes, minimum latency 1 cycle.
- Latency: a full word is presented on dn_we 1 cycle after its last byte's ioctl_wr.
- Config capture, single cycle, independent of the FSM:
  - DIP_INDEX: on ioctl_wr with addr < DIP_BYTES, dip_bank byte[addr] <= dout. Higher addresses are ignored.
  - MOD_INDEX: any ioctl_wr sets mod_byte <= dout.
- DATA_W == 8: packing degenerates; every ROM byte produces a write with dn_be = 1.

Optional Feature:
- Macro: IOCTL_ROM_ROUTER_CHECKSUM_EN.
- Defined: rom_sum is a 16-bit wrap-around sum of every in-range ROM byte accepted. It is cleared at download start and frozen after dl_done.
- Undefined: rom_sum is tied to 0 and no adder is synthesised.

Test Plan:
- DATA_W=16: bytes 0x11@0, 0x22@1 -> one write: dn_we=0001, dn_addr=0, dn_data=0x2211, dn_be=11; dl_done pulses once after ioctl_download falls.
- Stream of 3 bytes @0..2 then end of download -> writes 0x2211/be=11, then 0x0033/be=01 at dn_addr=1; exactly 2 writes.
- dn_ready held low 5 cycles while a new byte arrives -> ioctl_wait=1 throughout; the skid byte is preserved and written in the next word; no byte lost or duplicated.
- Byte at addr 0x40000 (NUM_REGIONS=4, REGION_AW=16) -> no dn_we, dl_overflow=1. It clears on the next ROM download start.
- DIP_INDEX writes 0xA5@1 and 0xFF@9 -> dip_bank[15:8]=0xA5, all other bytes unchanged. MOD_INDEX write 0x01 -> mod_byte=0x01.
- RESET_n low while in ISSUE -> dn_we and ioctl_wait are 0 asynchronously. After release, a new download starts with a clean accumulator; with the macro defined, rom_sum of bytes 0xFF,0x02 = 0x0101.
